// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer: steps each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK
// and drives the datapath mux selects and write enables. Define ILLEGAL_OPCODE_TRAP_EN to halt on illegal opcodes.
module multicycle_control_fsm #(
   parameter int OpcodeWidth = 4,
   parameter int SelectWidth = 4
) (
   input  logic                   clock,
   input  logic                   reset_n,
   input  logic [OpcodeWidth-1:0] opcode,
   input  logic                   zero,
   input  logic                   mem_ready,
   output logic                   mem_read,
   output logic                   mem_write,
   output logic                   ir_write,
   output logic                   pc_write,
   output logic                   reg_write,
   output logic [SelectWidth-1:0] pc_src_select,
   output logic [SelectWidth-1:0] wb_select,
   output logic [SelectWidth-1:0] alu_src_b_select,
   output logic [1:0]             alu_op,
   output logic [2:0]             state_out,
`ifdef ILLEGAL_OPCODE_TRAP_EN
   output logic                   illegal_op,
`endif
   output logic                   halted
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALT      = 3'd5
   } state_t;

   typedef enum logic [1:0] {PC_INC    = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_REG = 2'd3} pc_src_t;
   typedef enum logic [1:0] {WB_ALU    = 2'd0, WB_MEM    = 2'd1, WB_LINK = 2'd2, WB_IMM = 2'd3} wb_sel_t;
   typedef enum logic [1:0] {ALUB_REG  = 2'd0, ALUB_IMM  = 2'd1, ALUB_ONE = 2'd2, ALUB_ZERO = 2'd3} alu_b_t;
   typedef enum logic [1:0] {ALU_ADD   = 2'd0, ALU_SUB   = 2'd1, ALU_AND = 2'd2, ALU_OR = 2'd3} alu_op_t;

   localparam logic [OpcodeWidth-1:0] OP_NOP   = OpcodeWidth'(0);
   localparam logic [OpcodeWidth-1:0] OP_ADD   = OpcodeWidth'(1);
   localparam logic [OpcodeWidth-1:0] OP_ADDI  = OpcodeWidth'(2);
   localparam logic [OpcodeWidth-1:0] OP_LOAD  = OpcodeWidth'(3);
   localparam logic [OpcodeWidth-1:0] OP_STORE = OpcodeWidth'(4);
   localparam logic [OpcodeWidth-1:0] OP_BEQ   = OpcodeWidth'(5);
   localparam logic [OpcodeWidth-1:0] OP_JUMP  = OpcodeWidth'(6);
   localparam logic [OpcodeWidth-1:0] OP_JAL   = OpcodeWidth'(7);
   localparam logic [OpcodeWidth-1:0] OP_HALT  = OpcodeWidth'(15);

   state_t                 state_q, state_d;
   logic [OpcodeWidth-1:0] op_q;

   logic    mem_read_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c, halted_c;
   pc_src_t pc_src_c;
   wb_sel_t wb_c;
   alu_b_t  alu_b_c;
   alu_op_t alu_op_c;

   function automatic logic is_legal(input logic [OpcodeWidth-1:0] op);
      return (op <= OP_JAL) || (op == OP_HALT);
   endfunction

   // Instructions that need the EXECUTE step; the rest finish in DECODE.
   function automatic logic needs_execute(input logic [OpcodeWidth-1:0] op);
      return (op == OP_ADD) || (op == OP_ADDI) || (op == OP_LOAD) ||
             (op == OP_STORE) || (op == OP_BEQ);
   endfunction

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_FETCH;
         op_q    <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) op_q <= opcode;
      end
   end

`ifdef ILLEGAL_OPCODE_TRAP_EN
   logic illegal_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)                                     illegal_q <= 1'b0;
      else if (state_q == S_DECODE && !is_legal(opcode)) illegal_q <= 1'b1;
   end

   assign illegal_op = illegal_q;
`endif

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      ir_write_c  = 1'b0;
      pc_write_c  = 1'b0;
      reg_write_c = 1'b0;
      halted_c    = 1'b0;
      pc_src_c    = PC_INC;
      wb_c        = WB_ALU;
      alu_b_c     = ALUB_REG;
      alu_op_c    = ALU_ADD;

      case (state_q)
         S_FETCH: begin
            mem_read_c = 1'b1;
            if (mem_ready) begin
               ir_write_c = 1'b1;
               pc_write_c = 1'b1;
               pc_src_c   = PC_INC;
               alu_b_c    = ALUB_ONE;
               alu_op_c   = ALU_ADD;
               state_d    = S_DECODE;
            end
         end

         // The opcode register is still loading here, so DECODE looks at the live field.
         S_DECODE: begin
            if (opcode == OP_HALT) begin
               state_d = S_HALT;
            end else if (opcode == OP_JUMP) begin
               pc_write_c = 1'b1;
               pc_src_c   = PC_JUMP;
               state_d    = S_FETCH;
            end else if (opcode == OP_JAL) begin
               reg_write_c = 1'b1;
               wb_c        = WB_LINK;
               pc_write_c  = 1'b1;
               pc_src_c    = PC_JUMP;
               state_d     = S_FETCH;
            end else if (needs_execute(opcode)) begin
               state_d = S_EXECUTE;
            end else begin
`ifdef ILLEGAL_OPCODE_TRAP_EN
               state_d = is_legal(opcode) ? S_FETCH : S_HALT;
`else
               state_d = S_FETCH;
`endif
            end
         end

         S_EXECUTE: begin
            state_d = S_FETCH;
            if (op_q == OP_ADD) begin
               alu_b_c = ALUB_REG;
               state_d = S_WRITEBACK;
            end else if (op_q == OP_ADDI) begin
               alu_b_c = ALUB_IMM;
               state_d = S_WRITEBACK;
            end else if (op_q == OP_LOAD || op_q == OP_STORE) begin
               alu_b_c = ALUB_IMM;
               state_d = S_MEMORY;
            end else if (op_q == OP_BEQ) begin
               alu_b_c  = ALUB_REG;
               alu_op_c = ALU_SUB;
               if (zero) begin
                  pc_write_c = 1'b1;
                  pc_src_c   = PC_BRANCH;
               end
            end
         end

         S_MEMORY: begin
            state_d = S_FETCH;
            if (op_q == OP_LOAD) begin
               mem_read_c = 1'b1;
               state_d    = mem_ready ? S_WRITEBACK : S_MEMORY;
            end else if (op_q == OP_STORE) begin
               mem_write_c = 1'b1;
               state_d     = mem_ready ? S_FETCH : S_MEMORY;
            end
         end

         S_WRITEBACK: begin
            reg_write_c = 1'b1;
            wb_c        = (op_q == OP_LOAD) ? WB_MEM : WB_ALU;
            state_d     = S_FETCH;
         end

         S_HALT: halted_c = 1'b1;

         default: state_d = S_FETCH;
      endcase
   end

   // State is already FETCH under reset, but FETCH requests a read, so gate everything off.
   assign mem_read         = reset_n & mem_read_c;
   assign mem_write        = reset_n & mem_write_c;
   assign ir_write         = reset_n & ir_write_c;
   assign pc_write         = reset_n & pc_write_c;
   assign reg_write        = reset_n & reg_write_c;
   assign halted           = reset_n & halted_c;
   assign pc_src_select    = reset_n ? SelectWidth'(pc_src_c) : '0;
   assign wb_select        = reset_n ? SelectWidth'(wb_c)     : '0;
   assign alu_src_b_select = reset_n ? SelectWidth'(alu_b_c)  : '0;
   assign alu_op           = reset_n ? alu_op_c               : '0;
   assign state_out        = reset_n ? state_q                : '0;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized bench: a per-instruction trace model builds the expected cycle-by-cycle outputs
// from the instruction rules, then drives the DUT and compares every cycle.
module tb_multicycle_control_fsm;

   logic       clock = 1'b0;
   logic       reset_n = 1'b0;
   logic [3:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_read, mem_write, ir_write, pc_write, reg_write, halted;
   logic [3:0] pc_src_select, wb_select, alu_src_b_select;
   logic [1:0] alu_op;
   logic [2:0] state_out;
   logic       ill_obs;

   int n_cmp = 0;
   int n_bad = 0;
   logic exp_ill = 1'b0;

   typedef struct {
      logic        rdy;
      logic        zr;
      logic [3:0]  op;
      logic [31:0] exp;
   } ent_t;

   ent_t tr[$];

   multicycle_control_fsm #(.OpcodeWidth(4), .SelectWidth(4)) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .opcode           (opcode),
      .zero             (zero),
      .mem_ready        (mem_ready),
      .mem_read         (mem_read),
      .mem_write        (mem_write),
      .ir_write         (ir_write),
      .pc_write         (pc_write),
      .reg_write        (reg_write),
      .pc_src_select    (pc_src_select),
      .wb_select        (wb_select),
      .alu_src_b_select (alu_src_b_select),
      .alu_op           (alu_op),
      .state_out        (state_out),
`ifdef ILLEGAL_OPCODE_TRAP_EN
      .illegal_op       (ill_obs),
`endif
      .halted           (halted)
   );

`ifndef ILLEGAL_OPCODE_TRAP_EN
   assign ill_obs = 1'b0;
`endif

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] observed();
      return {8'd0, ill_obs, state_out, halted, mem_read, mem_write, ir_write, pc_write,
              reg_write, pc_src_select, wb_select, alu_src_b_select, alu_op};
   endfunction

   // en = {mem_read, mem_write, ir_write, pc_write, reg_write}
   function automatic logic [31:0] w(input int st, input logic [4:0] en, input int pcs,
                                     input int wb, input int ab, input int aop, input logic hlt);
      return {8'd0, exp_ill, 3'(st), hlt, en, 4'(pcs), 4'(wb), 4'(ab), 2'(aop)};
   endfunction

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [3:0] rop();
      return 4'($urandom_range(0, 15));
   endfunction

   task automatic push(input logic rdy, input logic zr, input logic [3:0] op, input logic [31:0] e);
      ent_t x;
      x.rdy = rdy; x.zr = zr; x.op = op; x.exp = e;
      tr.push_back(x);
   endtask

   task automatic do_reset_check(input string tag);
      reset_n = 1'b0;
      exp_ill = 1'b0;
      #1 check({tag, "_async"}, observed(), 32'd0);
      @(negedge clock);
      mem_ready = 1'b1;
      #1 check({tag, "_held"}, observed(), 32'd0);
      mem_ready = 1'b0;
      reset_n = 1'b1;
      #1 check({tag, "_release"}, observed(), w(0, 5'b10000, 0, 0, 0, 0, 1'b0));
   endtask

   // Build the expected trace of one instruction from the instruction rules, then play it.
   task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic z,
                            input int abort_at, input string tag);
      logic to_halt;
      logic trap;
`ifdef ILLEGAL_OPCODE_TRAP_EN
      trap = 1'b1;
`else
      trap = 1'b0;
`endif
      tr.delete();
      to_halt = 1'b0;

      for (int i = 0; i < fw; i++) push(1'b0, rbit(), rop(), w(0, 5'b10000, 0, 0, 0, 0, 1'b0));
      push(1'b1, rbit(), rop(), w(0, 5'b10110, 0, 0, 2, 0, 1'b0));

      case (op)
         4'd6:    push(rbit(), rbit(), op, w(1, 5'b00010, 2, 0, 0, 0, 1'b0));
         4'd7:    push(rbit(), rbit(), op, w(1, 5'b00011, 2, 2, 0, 0, 1'b0));
         default: push(rbit(), rbit(), op, w(1, 5'b00000, 0, 0, 0, 0, 1'b0));
      endcase
      if (op == 4'd15) to_halt = 1'b1;
      if (op >= 4'd8 && op <= 4'd14 && trap) begin
         to_halt = 1'b1;
         exp_ill = 1'b1;
      end

      case (op)
         4'd1:       push(rbit(), z, rop(), w(2, 5'b00000, 0, 0, 0, 0, 1'b0));
         4'd2, 4'd3,
         4'd4:       push(rbit(), z, rop(), w(2, 5'b00000, 0, 0, 1, 0, 1'b0));
         4'd5:       push(rbit(), z, rop(), z ? w(2, 5'b00010, 1, 0, 0, 1, 1'b0)
                                               : w(2, 5'b00000, 0, 0, 0, 1, 1'b0));
         default: ;
      endcase

      if (op == 4'd3 || op == 4'd4) begin
         for (int i = 0; i <= mw; i++)
            push(i == mw, rbit(), rop(),
                 w(3, (op == 4'd3) ? 5'b10000 : 5'b01000, 0, 0, 0, 0, 1'b0));
      end

      if (op >= 4'd1 && op <= 4'd3)
         push(rbit(), rbit(), rop(), w(4, 5'b00001, 0, (op == 4'd3) ? 1 : 0, 0, 0, 1'b0));

      if (to_halt)
         for (int i = 0; i < 20; i++) push(rbit(), rbit(), rop(), w(5, 5'b00000, 0, 0, 0, 0, 1'b1));

      for (int i = 0; i < tr.size(); i++) begin
         @(negedge clock);
         mem_ready = tr[i].rdy;
         zero      = tr[i].zr;
         opcode    = tr[i].op;
         #1 check($sformatf("%s_c%0d", tag, i), observed(), tr[i].exp);
         if (i == abort_at) begin
            do_reset_check({tag, "_abort"});
            return;
         end
      end

      if (to_halt) begin
         @(negedge clock);
         do_reset_check({tag, "_unhalt"});
      end
   endtask

   initial begin
      #2 check("reset_init", observed(), 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      #1 check("reset_release", observed(), w(0, 5'b10000, 0, 0, 0, 0, 1'b0));

      run_instr(4'd1, 0, 0, 1'b0, -1, "add");
      run_instr(4'd1, 1, 0, 1'b0, 3, "add_abort");
      run_instr(4'd1, 0, 0, 1'b0, -1, "add_after_abort");
      run_instr(4'd3, 0, 2, 1'b0, -1, "load_wait2");
      run_instr(4'd5, 0, 0, 1'b1, -1, "beq_taken");
      run_instr(4'd5, 0, 0, 1'b0, -1, "beq_not");
      run_instr(4'd7, 0, 0, 1'b0, -1, "jal");
      run_instr(4'd6, 2, 0, 1'b0, -1, "jump");
      run_instr(4'd4, 0, 1, 1'b0, -1, "store_wait1");
      run_instr(4'd2, 0, 0, 1'b0, -1, "addi");
      run_instr(4'd0, 0, 0, 1'b0, -1, "nop");
      run_instr(4'd9, 0, 0, 1'b0, -1, "illegal9");
      run_instr(4'd15, 0, 0, 1'b0, -1, "halt");

      for (int n = 0; n < 200; n++) begin
         logic [3:0] op;
         int fw, mw, ab;
         op = ($urandom_range(0, 15) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
         fw = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
         mw = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
         ab = (op >= 4'd1 && op <= 4'd5 && $urandom_range(0, 9) == 0) ? fw + 2 : -1;
         run_instr(op, fw, mw, rbit(), ab, $sformatf("rnd%0d_op%0d", n, op));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
